// File: rtl/timer_pkg.sv
// Shared constants for the microwave cook timer.
// State encoding, digit geometry and a BCD validity helper.
package timer_pkg;

    localparam int DIGITS  = 3;
    localparam int BCD_W   = 4;
    localparam int ENTRY_W = DIGITS * BCD_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ENTRY = 3'd1;
    localparam logic [2:0] COOK  = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/timer_entry_reg.sv
// Keypad entry register: 3 BCD digits, shifted left on each valid key.
// Non-BCD keys are dropped; the oldest (minutes) digit falls off the top.
module timer_entry_reg
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               clrn,
    input  logic               clr,
    input  logic               shift,
    input  logic [BCD_W-1:0]   digit,
    output logic [ENTRY_W-1:0] value
);

    // shift a new seconds-ones digit in, or wipe the entry
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (shift && bcd_ok(digit))
            value <= {value[ENTRY_W-BCD_W-1:0], digit};
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook timer sequencer: keypad entry, counter load/enable, cook FSM.
// All outputs are registered; cnt_data is the entry register itself.
module microwave_timer_ctrl
    import timer_pkg::*;
#(
    parameter int BEEP_TICKS = 3
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               tick,
    input  logic               key_valid,
    input  logic [BCD_W-1:0]   key_digit,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               door_closed,
    input  logic [ENTRY_W-1:0] cnt_val,
    output logic [ENTRY_W-1:0] cnt_data,
    output logic               cnt_loadn,
    output logic               cnt_clrn,
    output logic               cnt_en,
    output logic               magnetron,
    output logic               done,
    output logic               beep,
    output logic [2:0]         state
);

    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    logic [2:0]    nxt;
    logic          key_ok;
    logic          start_ok;
    logic          load;
    logic          run_en;
    logic          cnt_zero;
    logic          settled;
    logic [BW-1:0] beep_cnt;

    assign cnt_zero = (cnt_val == '0);
    // cnt_val is stale during the load cycle; ignore it until loaded
    assign settled  = cnt_loadn;
    assign start_ok = start && door_closed && !stop;

    timer_entry_reg u_entry (
        .clk   (clk),
        .clrn  (clrn),
        .clr   (clear),
        .shift (key_ok),
        .digit (key_digit),
        .value (cnt_data)
    );

    // next state, key acceptance, load request and count enable
    always_comb begin
        nxt    = state;
        load   = 1'b0;
        run_en = 1'b0;
        key_ok = key_valid && bcd_ok(key_digit)
                 && !clear && !stop && !start
                 && (state == IDLE || state == ENTRY);
        if (clear) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (key_ok)
                        nxt = ENTRY;
                end
                ENTRY: begin
                    if (start_ok && cnt_data != '0) begin
                        nxt  = COOK;
                        load = 1'b1;
                    end
                end
                COOK: begin
                    if (!door_closed || stop)
                        nxt = PAUSE;
                    else if (settled && cnt_zero)
                        nxt = DONE;
                    else
                        run_en = tick && settled && !cnt_zero;
                end
                PAUSE: begin
                    if (start_ok)
                        nxt = COOK;
                end
                DONE: begin
                    if (!door_closed)
                        nxt = IDLE;
                    else if (tick && beep_cnt == BEEP_LAST)
                        nxt = IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            cnt_loadn <= 1'b1;
            cnt_clrn  <= 1'b1;
            cnt_en    <= 1'b0;
            magnetron <= 1'b0;
            done      <= 1'b0;
            beep      <= 1'b0;
        end else begin
            state     <= nxt;
            cnt_loadn <= !load;
            cnt_clrn  <= !clear;
            cnt_en    <= run_en;
            magnetron <= (nxt == COOK);
            done      <= (nxt == DONE);
            beep      <= (nxt == DONE);
        end
    end

    // ticks heard while beeping; cleared on any exit from DONE
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            beep_cnt <= '0;
        else if (state == DONE && nxt == DONE)
            beep_cnt <= beep_cnt + BW'(tick);
        else
            beep_cnt <= '0;
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed vector table, async reset
// sequence, and randomized traffic against a decimal reference model.
module tb_microwave_timer_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;
    localparam int BEEPS   = 3;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] data;
        logic        ld;
        logic        cl;
        logic        en;
        logic        mg;
        logic        dn;
        logic        bp;
    } out_t;

    typedef struct packed {
        logic       kv;
        logic [3:0] kd;
        logic       sa;
        logic       so;
        logic       cl;
        logic       dr;
        logic       tk;
    } in_t;

    typedef struct {
        in_t         i;
        logic [11:0] cv;
        out_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        door_closed = 1'b1;
    logic [11:0] cnt_val = 12'h000;
    logic [11:0] cnt_data;
    logic        cnt_loadn;
    logic        cnt_clrn;
    logic        cnt_en;
    logic        magnetron;
    logic        done;
    logic        beep;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state (decimal values, not BCD registers)
    int   m_mode;
    int   m_entry;
    int   m_cnt;
    int   m_beeps;
    out_t m_exp;

    vec_t tbl[$];

    microwave_timer_ctrl #(.BEEP_TICKS(BEEPS)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tick        (tick),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .cnt_val     (cnt_val),
        .cnt_data    (cnt_data),
        .cnt_loadn   (cnt_loadn),
        .cnt_clrn    (cnt_clrn),
        .cnt_en      (cnt_en),
        .magnetron   (magnetron),
        .done        (done),
        .beep        (beep),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.st = state;
        o.data = cnt_data;
        o.ld = cnt_loadn;
        o.cl = cnt_clrn;
        o.en = cnt_en;
        o.mg = magnetron;
        o.dn = done;
        o.bp = beep;
        return o;
    endfunction

    function automatic out_t rst_out();
        out_t o;
        o = '0;
        o.ld = 1'b1;
        o.cl = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(
        input logic kv, input logic [3:0] kd,
        input logic sa, input logic so, input logic cl,
        input logic dr, input logic tk, input logic [11:0] cv,
        input logic [2:0] est, input logic [11:0] edat,
        input logic eld, input logic ecl, input logic een,
        input logic emg, input logic edn, input logic ebp);
        vec_t v;
        v.i = '{kv, kd, sa, so, cl, dr, tk};
        v.cv = cv;
        v.e = '{est, edat, eld, ecl, een, emg, edn, ebp};
        return v;
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got st=%0d data=%h ld=%b cl=%b en=%b mg=%b dn=%b bp=%b, want st=%0d data=%h ld=%b cl=%b en=%b mg=%b dn=%b bp=%b",
                     name, $time, got.st, got.data, got.ld, got.cl, got.en,
                     got.mg, got.dn, got.bp, want.st, want.data, want.ld,
                     want.cl, want.en, want.mg, want.dn, want.bp);
        end
    endtask

    task automatic apply(input in_t i);
        key_valid = i.kv;
        key_digit = i.kd;
        start = i.sa;
        stop = i.so;
        clear = i.cl;
        door_closed = i.dr;
        tick = i.tk;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_entry = 0;
        m_cnt = 0;
        m_beeps = 0;
        m_exp = rst_out();
    endtask

    // One clock of the controller as described in words, plus the
    // external decade counter chain it drives.
    task automatic model_step(input in_t i);
        int   nmode, nentry, ncnt, nbeeps;
        bit   key_ok, start_ok, loaded, load, en;
        out_t n;
        nmode = m_mode;
        nentry = m_entry;
        nbeeps = 0;
        load = 0;
        en = 0;
        loaded = m_exp.ld;
        start_ok = i.sa && i.dr && !i.so;
        key_ok = i.kv && (i.kd < 10) && !i.sa && !i.so && !i.cl
                 && (m_mode == M_IDLE || m_mode == M_ENTRY);
        if (!m_exp.cl)
            ncnt = 0;
        else if (!m_exp.ld)
            ncnt = m_entry;
        else if (m_exp.en)
            ncnt = (m_cnt == 0) ? 999 : m_cnt - 1;
        else
            ncnt = m_cnt;
        if (i.cl) begin
            nmode = M_IDLE;
            nentry = 0;
        end else if (m_mode == M_IDLE) begin
            if (key_ok) nmode = M_ENTRY;
        end else if (m_mode == M_ENTRY) begin
            if (start_ok && m_entry != 0) begin
                nmode = M_COOK;
                load = 1;
            end
        end else if (m_mode == M_COOK) begin
            if (!i.dr || i.so)
                nmode = M_PAUSE;
            else if (loaded && m_cnt == 0)
                nmode = M_DONE;
            else
                en = i.tk && loaded && (m_cnt != 0);
        end else if (m_mode == M_PAUSE) begin
            if (start_ok) nmode = M_COOK;
        end else begin
            nbeeps = m_beeps + (i.tk ? 1 : 0);
            if (!i.dr || nbeeps >= BEEPS) begin
                nmode = M_IDLE;
                nbeeps = 0;
            end
        end
        if (key_ok)
            nentry = (m_entry % 100) * 10 + int'(i.kd);
        n.st = 3'(nmode);
        n.data = bcd(nentry);
        n.ld = !load;
        n.cl = !i.cl;
        n.en = en;
        n.mg = (nmode == M_COOK);
        n.dn = (nmode == M_DONE);
        n.bp = (nmode == M_DONE);
        m_mode = nmode;
        m_entry = nentry;
        m_cnt = ncnt;
        m_beeps = nbeeps;
        m_exp = n;
    endtask

    initial begin
        in_t  idle_in;
        out_t w;
        bit   door_r;

        idle_in = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        //          kv kd    sa so cl dr tk cv       st data    ld cl en mg dn bp
        tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1, 0, 12'h000, 1, 12'h001, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 0, 1, 0, 12'h000, 1, 12'h013, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0, 12'h000, 1, 12'h130, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 0, 0, 1, 0, 12'h000, 1, 12'h130, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0, 12'h000, 2, 12'h130, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 12'h000, 2, 12'h130, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 12'h130, 2, 12'h130, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 12'h130, 2, 12'h130, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 12'h129, 2, 12'h130, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 12'h001, 2, 12'h130, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 12'h000, 4, 12'h130, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 12'h000, 4, 12'h130, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 12'h000, 4, 12'h130, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 12'h000, 4, 12'h130, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 12'h000, 0, 12'h130, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 0, 0, 1, 0, 12'h000, 1, 12'h302, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0, 12'h000, 2, 12'h302, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 12'h302, 2, 12'h302, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 12'h302, 3, 12'h302, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 12'h302, 3, 12'h302, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 1, 0, 1, 0, 12'h302, 3, 12'h302, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0, 12'h302, 2, 12'h302, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 1, 1, 12'h302, 3, 12'h302, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0, 12'h302, 0, 12'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 12'h000, 0, 12'h000, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 0, 1, 0, 12'h000, 1, 12'h001, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 0, 0, 1, 0, 12'h000, 1, 12'h012, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 0, 1, 0, 12'h000, 1, 12'h123, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 0, 0, 1, 0, 12'h000, 1, 12'h234, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 0, 0, 1, 0, 12'h000, 1, 12'h234, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 1, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0, 12'h000, 1, 12'h000, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0, 12'h000, 1, 12'h000, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 0, 0, 0, 0, 12'h000, 1, 12'h005, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 12'h000, 1, 12'h005, 1, 1, 0, 0, 0, 0));

        // reset state
        apply(idle_in);
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_out(), rst_out());
        clrn = 1'b1;

        // directed vectors, one row per clock
        foreach (tbl[k]) begin
            apply(tbl[k].i);
            cnt_val = tbl[k].cv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), dut_out(), tbl[k].e);
        end

        // async reset in the middle of a cook
        apply(idle_in);
        start = 1'b1;
        @(posedge clk);
        #1;
        w = '{3'd2, 12'h005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        check("cook_before_rst", dut_out(), w);
        apply(idle_in);
        cnt_val = 12'h005;
        @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst", dut_out(), rst_out());
        @(negedge clk);
        clrn = 1'b1;
        cnt_val = 12'h000;
        @(posedge clk);
        #1;
        check("after_rst", dut_out(), rst_out());

        // randomized traffic against the reference model
        clrn = 1'b0;
        apply(idle_in);
        @(posedge clk);
        #1;
        model_reset();
        cnt_val = bcd(m_cnt);
        clrn = 1'b1;
        door_r = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            in_t ri;
            ri.tk = ($urandom_range(0, 3) == 0);
            ri.sa = ($urandom_range(0, 9) == 0);
            ri.so = ($urandom_range(0, 39) == 0);
            ri.cl = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 59) == 0)
                door_r = !door_r;
            ri.dr = door_r;
            ri.kv = !(ri.sa || ri.so || ri.cl)
                    && ($urandom_range(0, 3) == 0);
            ri.kd = 4'($urandom_range(0, 11));
            apply(ri);
            model_step(ri);
            @(posedge clk);
            #1;
            check("rand", dut_out(), m_exp);
            cnt_val = bcd(m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
